// File: rtl/sram_init_port.sv
// SRAM front end: sweeps INIT_VALUE into every address after reset or on request,
// then forwards bridge accesses and returns read data through a registered stage.
module sram_init_port #(
  parameter int                         SRAM_DATA_WIDTH = 32,
  parameter int                         SRAM_ADDR_WIDTH = 8,
  parameter int                         SRAM_STRB_WIDTH = 8,
  parameter logic [SRAM_DATA_WIDTH-1:0] INIT_VALUE      = '0,
  localparam int                        LANES           = SRAM_DATA_WIDTH / SRAM_STRB_WIDTH
) (
  input  logic                       AIX_CLK,
  input  logic                       RST,
  input  logic                       INIT_REQ,
  output logic                       INIT_DONE,
  input  logic                       BR_REQ,
  output logic                       BR_READY,
  input  logic [SRAM_ADDR_WIDTH-1:0] BR_ADDR,
  input  logic [SRAM_DATA_WIDTH-1:0] BR_DATA_W,
  input  logic [LANES-1:0]           BR_W_EN,
  output logic                       BR_RVALID,
  output logic [SRAM_DATA_WIDTH-1:0] BR_DATA_R,
  output logic                       SRAM_EN,
  output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic [SRAM_DATA_WIDTH-1:0] SRAM_DATA_W,
  output logic [LANES-1:0]           SRAM_W_EN,
  input  logic [SRAM_DATA_WIDTH-1:0] SRAM_DATA_R
);

  if (SRAM_DATA_WIDTH % SRAM_STRB_WIDTH != 0) begin : g_bad_strb
    $error("SRAM_DATA_WIDTH must be a multiple of SRAM_STRB_WIDTH");
  end

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [SRAM_ADDR_WIDTH-1:0] r_cnt;
  logic [SRAM_ADDR_WIDTH-1:0] w_cnt_next;
  logic                       r_rd_p1;
  logic                       r_rvalid;
  logic [SRAM_DATA_WIDTH-1:0] r_data_r;
  logic                       w_rd_accept;

  // Reads are accepted only in RUN; writes are any request with a lane enabled.
  assign w_rd_accept = (r_state == ST_RUN) && BR_REQ && (BR_W_EN == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge AIX_CLK) begin
    if (RST) begin
      r_state  <= ST_INIT;
      r_cnt    <= '0;
      r_rd_p1  <= 1'b0;
      r_rvalid <= 1'b0;
      r_data_r <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_rd_p1  <= w_rd_accept;
      r_rvalid <= r_rd_p1;
      if (r_rd_p1) begin
        r_data_r <= SRAM_DATA_R;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case statement can leave a latch behind.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    INIT_DONE    = 1'b0;
    BR_READY     = 1'b0;
    SRAM_EN      = 1'b1;
    SRAM_ADDR    = r_cnt;
    SRAM_DATA_W  = INIT_VALUE;
    SRAM_W_EN    = '1;
    case (r_state)
      ST_INIT: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == '1) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        INIT_DONE   = 1'b1;
        BR_READY    = 1'b1;
        SRAM_EN     = BR_REQ;
        SRAM_ADDR   = BR_ADDR;
        SRAM_DATA_W = BR_DATA_W;
        SRAM_W_EN   = BR_REQ ? BR_W_EN : '0;
        if (INIT_REQ) begin
          w_state_next = ST_INIT;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = ST_INIT;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign BR_RVALID = r_rvalid;
  assign BR_DATA_R = r_data_r;

endmodule

// File: tb/tb_sram_init_port.sv
// Bench for sram_init_port: behavioural SRAM, vector table for run-mode accesses,
// read scoreboard checking data and 2-cycle latency, plus init/reset sequences.
module tb_sram_init_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_req;
  logic        init_done;
  logic        br_req;
  logic        br_ready;
  logic [7:0]  br_addr;
  logic [31:0] br_data_w;
  logic [3:0]  br_w_en;
  logic        br_rvalid;
  logic [31:0] br_data_r;
  logic        sram_en;
  logic [7:0]  sram_addr;
  logic [31:0] sram_data_w;
  logic [3:0]  sram_w_en;
  logic [31:0] sram_data_r;

  sram_init_port dut (
    .AIX_CLK     (clk),
    .RST         (rst),
    .INIT_REQ    (init_req),
    .INIT_DONE   (init_done),
    .BR_REQ      (br_req),
    .BR_READY    (br_ready),
    .BR_ADDR     (br_addr),
    .BR_DATA_W   (br_data_w),
    .BR_W_EN     (br_w_en),
    .BR_RVALID   (br_rvalid),
    .BR_DATA_R   (br_data_r),
    .SRAM_EN     (sram_en),
    .SRAM_ADDR   (sram_addr),
    .SRAM_DATA_W (sram_data_w),
    .SRAM_W_EN   (sram_w_en),
    .SRAM_DATA_R (sram_data_r)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port SRAM with one-cycle read latency.
  logic [31:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | i;
    sram_data_r = '0;
  end
  always @(posedge clk) begin
    if (sram_en) begin
      for (int l = 0; l < 4; l++)
        if (sram_w_en[l]) mem[sram_addr][l*8 +: 8] <= sram_data_w[l*8 +: 8];
      sram_data_r <= mem[sram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_exp_t;
  rd_exp_t sb[$];

  always @(negedge clk) begin
    if (br_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        rd_exp_t e;
        e = sb.pop_front();
        check("rvalid_cycle", cyc, e.due);
        check("rd_data", br_data_r, e.data);
      end
    end
  end

  typedef struct {
    logic        req;
    logic [3:0]  wen;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[14];

  // Called at posedge+#1; drives one access, checks pass-through, returns at posedge+#1.
  task automatic apply(input vec_t v, input string name);
    br_req    = v.req;
    br_w_en   = v.wen;
    br_addr   = v.addr;
    br_data_w = v.data;
    @(negedge clk);
    check({name, "_ready"}, br_ready, 1'b1);
    check({name, "_sram_en"}, sram_en, v.req);
    check({name, "_sram_wen"}, sram_w_en, v.req ? v.wen : 4'h0);
    if (v.req) check({name, "_sram_addr"}, sram_addr, v.addr);
    if (v.req && v.wen != 4'h0) check({name, "_sram_wdata"}, sram_data_w, v.data);
    if (v.req && v.wen == 4'h0) sb.push_back('{data: v.exp, due: cyc + 2});
    @(posedge clk); #1;
  endtask

  // Called in init cycle 0 (before its negedge); verifies the full sweep.
  task automatic init_sweep(input string name, input bit poke);
    int bad = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (!(sram_en === 1'b1 && sram_addr === 8'(k) && sram_w_en === 4'hf &&
            sram_data_w === 32'h0 && br_ready === 1'b0 && init_done === 1'b0)) bad++;
      if (poke) begin
        if (k == 50) init_req = 1'b1;
        if (k == 51) init_req = 1'b0;
        if (k == 60) begin
          br_req = 1'b1; br_w_en = 4'hf; br_addr = 8'h10; br_data_w = 32'hFFFF_FFFF;
        end
        if (k == 62) br_req = 1'b0;
      end
    end
    check({name, "_bad_cycles"}, bad, 0);
    @(negedge clk);
    check({name, "_done"}, init_done, 1'b1);
    check({name, "_ready"}, br_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 4'hf, 8'h10, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b1, 4'h0, 8'h10, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 4'h2, 8'h10, 32'h0000AB00, 32'h0};
    vecs[3]  = '{1'b1, 4'h0, 8'h10, 32'h0,        32'hDEADABEF};
    vecs[4]  = '{1'b1, 4'hf, 8'h01, 32'h11111111, 32'h0};
    vecs[5]  = '{1'b1, 4'h5, 8'h02, 32'h22222222, 32'h0};
    vecs[6]  = '{1'b1, 4'h8, 8'h03, 32'h33445566, 32'h0};
    vecs[7]  = '{1'b1, 4'h0, 8'h01, 32'h0,        32'h11111111};
    vecs[8]  = '{1'b1, 4'h0, 8'h02, 32'h0,        32'h00220022};
    vecs[9]  = '{1'b1, 4'h0, 8'h03, 32'h0,        32'h33000000};
    vecs[10] = '{1'b0, 4'hf, 8'h07, 32'h12345678, 32'h0};
    vecs[11] = '{1'b1, 4'h0, 8'h00, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 4'hf, 8'h05, 32'hCAFEF00D, 32'h0};
    vecs[13] = '{1'b1, 4'h0, 8'h05, 32'h0,        32'hCAFEF00D};

    rst = 1'b1; init_req = 1'b0; br_req = 1'b0;
    br_addr = '0; br_data_w = '0; br_w_en = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_init_done", init_done, 1'b0);
    check("rst_br_ready", br_ready, 1'b0);
    check("rst_rvalid", br_rvalid, 1'b0);
    check("rst_data_r", br_data_r, 32'h0);
    check("rst_sram_en", sram_en, 1'b1);
    check("rst_sram_addr", sram_addr, 8'h0);
    check("rst_sram_wen", sram_w_en, 4'hf);
    @(posedge clk); #1;
    rst = 1'b0;
    init_sweep("init1", 1'b0);

    for (int i = 0; i < 14; i++) apply(vecs[i], $sformatf("vec%0d", i));
    br_req = 1'b0;
    drain("table");

    // Read accepted on the INIT_REQ cycle returns during the re-init.
    br_req = 1'b1; br_w_en = 4'h0; br_addr = 8'h10; init_req = 1'b1;
    @(negedge clk);
    check("initreq_ready", br_ready, 1'b1);
    sb.push_back('{data: 32'hDEADABEF, due: cyc + 2});
    @(posedge clk); #1;
    br_req = 1'b0; init_req = 1'b0;
    init_sweep("init2", 1'b1);
    check("init2_sb_empty", sb.size(), 0);

    apply('{1'b1, 4'h0, 8'h10, 32'h0, 32'h0}, "post_rd10");
    apply('{1'b1, 4'h0, 8'h03, 32'h0, 32'h0}, "post_rd03");
    br_req = 1'b0;
    drain("post");

    // Reset during an in-flight read drops the response.
    br_req = 1'b1; br_w_en = 4'h0; br_addr = 8'h01;
    @(posedge clk); #1;
    br_req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("drop_rvalid", br_rvalid, 1'b0);
    check("drop_data_r", br_data_r, 32'h0);
    check("drop_addr0", sram_addr, 8'h0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("mid_init_addr100", sram_addr, 8'd100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    init_sweep("init3", 1'b0);

    apply('{1'b1, 4'h0, 8'h05, 32'h0, 32'h0}, "final_rd05");
    br_req = 1'b0;
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
